// File: rtl/add_serial_n.sv
// Digit-serial adder/subtractor. Each cycle processes one D-bit digit, LSB digit first,
// so an N-bit operation takes N/D cycles. Operands and result move over valid/ready handshakes.
module add_serial_n #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    // state | meaning
    // IDLE  | waiting for an operand set, in_ready high
    // RUN   | one digit per cycle through the D-bit carry chain
    // DONE  | result presented on sum/cout/ovf until out_ready

    localparam int ND = N / D;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    if (D < 1 || D > N || (N % D) != 0) begin : g_param_check
        $error("add_serial_n: D must divide N and satisfy 1 <= D <= N");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          carry;
    logic [CW-1:0] cnt;

    logic [D:0]    digit;
    logic [N-1:0]  a_next;
    logic [N-1:0]  b_next;
    logic          ovf_digit;

    assign digit = {1'b0, a_sh[D-1:0]} + {1'b0, b_sh[D-1:0]} + (D+1)'(carry);

    // Carry into the digit MSB is recovered as a^b^s of that bit, so no separate
    // narrower adder is needed to find it; this also covers D=1.
    assign ovf_digit = a_sh[D-1] ^ b_sh[D-1] ^ digit[D-1] ^ digit[D];

    // The a register doubles as the result accumulator: consumed digits shift out
    // at the bottom while result digits enter at the top.
    if (D == N) begin : g_single
        assign a_next = digit[D-1:0];
        assign b_next = '0;
    end else begin : g_multi
        assign a_next = {digit[D-1:0], a_sh[N-1:D]};
        assign b_next = {{D{1'b0}}, b_sh[N-1:D]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b ^ {N{sub}};
                        carry    <= cin ^ sub;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_next;
                    b_sh  <= b_next;
                    carry <= digit[D];
                    if (cnt == LAST) begin
                        sum       <= a_next;
                        cout      <= digit[D];
                        ovf       <= ovf_digit;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial_n.sv
// Bench for add_serial_n: three builds (D=4, D=16, D=1) checked against an arithmetic model
// of a+b+cin / a-b-cin with handshake, latency and hold behaviour.
module tb_add_serial_n;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    bit rand_mode = 1'b0;

    logic         iv[3], ir[3], cin_i[3], sub_i[3], ov[3], ord[3], oc[3], oo[3];
    logic [N-1:0] a_i[3], b_i[3], os[3];
    logic [N-1:0] es[3];
    logic         ec[3], eo[3], pend[3];
    int           acc_cyc[3];

    add_serial_n #(.N(N), .D(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]), .sub(sub_i[0]),
        .out_valid(ov[0]), .out_ready(ord[0]), .sum(os[0]), .cout(oc[0]), .ovf(oo[0])
    );

    add_serial_n #(.N(N), .D(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_i[1]), .b(b_i[1]), .cin(cin_i[1]), .sub(sub_i[1]),
        .out_valid(ov[1]), .out_ready(ord[1]), .sum(os[1]), .cout(oc[1]), .ovf(oo[1])
    );

    add_serial_n #(.N(N), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_i[2]), .b(b_i[2]), .cin(cin_i[2]), .sub(sub_i[2]),
        .out_valid(ov[2]), .out_ready(ord[2]), .sum(os[2]), .cout(oc[2]), .ovf(oo[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Returns {cout, ovf, sum} from plain integer arithmetic.
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic c, input logic s);
        int unsigned full;
        logic [N-1:0] r;
        logic co, v;
        if (!s) begin
            full = x + y + c;
            r    = full[N-1:0];
            co   = full[N];
            v    = (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
        end else begin
            r  = x - y - c;
            co = (int'(x) >= int'(y) + int'(c));
            v  = (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
        end
        return {co, v, r};
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return N'($urandom);
        endcase
    endfunction

    task automatic op(input int i, input logic [N-1:0] x, input logic [N-1:0] y,
                      input logic c, input logic s);
        int t;
        logic [N+1:0] m;
        @(negedge clk);
        a_i[i] = x; b_i[i] = y; cin_i[i] = c; sub_i[i] = s; iv[i] = 1'b1;
        t = 0;
        while (!ir[i] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ir[i]) begin
            chk($sformatf("accept_timeout[%0d]", i), ir[i], 1);
            iv[i] = 1'b0;
            return;
        end
        @(negedge clk);
        iv[i] = 1'b0;
        m = model(x, y, c, s);
        {ec[i], eo[i], es[i]} = m;
        acc_cyc[i] = cyc;
        pend[i] = 1'b1;
        a_i[i] = N'($urandom); b_i[i] = N'($urandom);
        cin_i[i] = 1'($urandom); sub_i[i] = 1'($urandom);
    endtask

    task automatic wait_out(input int i);
        int t;
        t = 0;
        while (!ov[i] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("out_valid_timeout[%0d]", i), ov[i], 1);
    endtask

    task automatic release_out(input int i);
        @(posedge clk); #1 ord[i] = 1'b1;
        @(posedge clk); #1 ord[i] = 1'b0;
        chk($sformatf("out_valid_drop[%0d]", i), ov[i], 0);
        chk($sformatf("in_ready_back[%0d]", i), ir[i], 1);
    endtask

    task automatic dir(input string nm, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic c, input logic s, input logic [N+1:0] want);
        chk({nm, "_model"}, model(x, y, c, s), want);
        op(0, x, y, c, s);
        wait_out(0);
        chk({nm, "_dut"}, {oc[0], oo[0], os[0]}, want);
        release_out(0);
    endtask

    task automatic run_rand(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            logic [N-1:0] x;
            logic [N-1:0] y;
            x = pick();
            y = pick();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op(i, x, y, 1'($urandom), 1'($urandom));
        end
    endtask

    // One compare process per build: every cycle out_valid is high the outputs must
    // equal the model result of the outstanding op.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int LAT = (g == 0) ? 4 : (g == 1) ? 1 : 16;
        initial begin
            logic prev;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev = 1'b0;
                end else begin
                    if (ov[g]) begin
                        chk($sformatf("result_expected[%0d]", g), pend[g], 1);
                        if (pend[g]) begin
                            if (!prev) chk($sformatf("latency[%0d]", g), cyc - acc_cyc[g], LAT);
                            chk($sformatf("sum[%0d]", g), os[g], es[g]);
                            chk($sformatf("cout[%0d]", g), oc[g], ec[g]);
                            chk($sformatf("ovf[%0d]", g), oo[g], eo[g]);
                            chk($sformatf("in_ready_done[%0d]", g), ir[g], 0);
                            if (ord[g]) pend[g] = 1'b0;
                        end
                    end
                    prev = ov[g];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode)
                for (int i = 0; i < 3; i++) ord[i] = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int t;
        bit busy;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ord[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
            cin_i[i] = 1'b0; sub_i[i] = 1'b0; pend[i] = 1'b0;
            es[i] = '0; ec[i] = 1'b0; eo[i] = 1'b0; acc_cyc[i] = 0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid[%0d]", i), ov[i], 0);
            chk($sformatf("rst_result[%0d]", i), {oc[i], oo[i], os[i]}, 0);
            chk($sformatf("rst_in_ready[%0d]", i), ir[i], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        dir("T1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h20000);
        dir("T2a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h18000);
        dir("T2b", 16'h1234, 16'h4321, 1'b1, 1'b0, 18'h05556);
        dir("T3a", 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
        dir("T3b", 16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);

        // Stall in DONE while in_valid pulses with other operands.
        op(0, 16'h0102, 16'h0304, 1'b0, 1'b0);
        wait_out(0);
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1;
            a_i[0] = N'($urandom);
            @(negedge clk);
            chk("T4_in_ready", ir[0], 0);
            chk("T4_out_valid", ov[0], 1);
            chk("T4_result", {oc[0], oo[0], os[0]}, 18'h00406);
        end
        iv[0] = 1'b0;
        release_out(0);
        op(0, 16'hFFF0, 16'h0010, 1'b1, 1'b1);
        wait_out(0);
        chk("T4_b2b", {oc[0], oo[0], os[0]}, 18'h2FFDF);
        release_out(0);

        // Abort during the second RUN cycle.
        op(0, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("T5_out_valid", ov[0], 0);
        chk("T5_result", {oc[0], oo[0], os[0]}, 0);
        chk("T5_in_ready", ir[0], 1);
        pend[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("T5_idle_after", ir[0], 1);
        dir("T5_next", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 18'h20000);

        rand_mode = 1'b1;
        fork
            run_rand(0, 400);
            run_rand(1, 1000);
            run_rand(2, 1000);
        join
        @(posedge clk);
        #2;
        rand_mode = 1'b0;
        for (int i = 0; i < 3; i++) ord[i] = 1'b1;
        t = 0;
        busy = 1'b1;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
            busy = pend[0] | pend[1] | pend[2];
        end
        for (int i = 0; i < 3; i++) chk($sformatf("drain[%0d]", i), pend[i], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
